sdram_read: RTL

- Full-page burst-read engine for the 166 MHz SDRAM controller; the read-side counterpart of the burst-write engine.
- On a granted read request it issues ACTIVE, READ, BURST-STOP and PRECHARGE, then captures the returned DQ words.
- It presents the words to the read FIFO with a per-word valid strobe.
- The arbiter muxes read_cmd/read_ba/read_addr onto the SDRAM pins.

---
 rtl/sdram_read_if.sv | 28 ++
 rtl/sdram_read.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sdram_read_if.sv
// Read-engine side of the SDRAM controller: request, DQ capture and command bus.
// Latency: none, pure signal bundle.
// Backpressure: none; rd_ack is a write strobe the read FIFO must always accept.
interface sdram_read_if;
   logic        init_end;
   logic        rd_en;
   logic [23:0] rd_addr;
   logic [9:0]  rd_burst_len;
   logic [15:0] rd_data;
   logic        rd_ack;
   logic        rd_end;
   logic [3:0]  read_cmd;
   logic [1:0]  read_ba;
   logic [12:0] read_addr;
   logic [15:0] rd_sdram_data;

   // Arbiter / PHY / FIFO side
   modport master (
      output init_end, rd_en, rd_addr, rd_burst_len, rd_data,
      input  rd_ack, rd_end, read_cmd, read_ba, read_addr, rd_sdram_data
   );

   // Read engine side
   modport slave (
      input  init_end, rd_en, rd_addr, rd_burst_len, rd_data,
      output rd_ack, rd_end, read_cmd, read_ba, read_addr, rd_sdram_data
   );
endinterface

// File: rtl/sdram_read.sv
// Full-page burst read engine: ACTIVE, READ, BURST-STOP, PRECHARGE, then DQ capture.
// Latency: READ on bus TRCD_CLK+3 cycles after rd_en; word k on rd_sdram_data at READ+CAS_LAT+1+k.
// Backpressure: none; rd_en outside idle is ignored and every rd_ack word must be taken.
module sdram_read #(
   parameter int TRCD_CLK = 2,
   parameter int TRP_CLK  = 2,
   parameter int CAS_LAT  = 3
) (
   input  logic         sys_clk,
   input  logic         sys_rst,
   sdram_read_if.slave  bus
);

   localparam logic [3:0] CMD_NOP   = 4'b0111;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_READ  = 4'b0101;
   localparam logic [3:0] CMD_BSTOP = 4'b0110;
   localparam logic [3:0] CMD_PRE   = 4'b0010;

   // Precharge dwell also covers CAS latency so the last word has landed before rd_end.
   localparam int         TRP_DWELL = (TRP_CLK > CAS_LAT) ? TRP_CLK : CAS_LAT;
   localparam logic [9:0] TRCD_LAST = 10'(TRCD_CLK - 1);
   localparam logic [9:0] TRP_LAST  = 10'(TRP_DWELL - 1);

   typedef enum logic [2:0] {
      RD_IDLE, RD_ACTIVE, RD_TRCD, RD_READ, RD_DATA, RD_PRE, RD_TRP, RD_END
   } state_t;

   state_t       state, state_nxt;
   logic [9:0]   cnt;
   logic         cnt_clr;
   logic         start;
   logic [23:0]  addr_q;
   logic [9:0]   len_q;
   logic [3:0]   cmd_nxt;
   logic [1:0]   ba_nxt;
   logic [12:0]  addr_nxt;
   logic [CAS_LAT-1:0] dwin;

   // Next state and the command for the current state (registered below)
   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      start     = 1'b0;
      cmd_nxt   = CMD_NOP;
      ba_nxt    = 2'b11;
      addr_nxt  = 13'h1fff;
      case (state)
         RD_IDLE: begin
            cnt_clr = 1'b1;
            if (bus.rd_en && bus.init_end) begin
               start     = 1'b1;
               state_nxt = RD_ACTIVE;
            end
         end
         RD_ACTIVE: begin
            cmd_nxt   = CMD_ACT;
            ba_nxt    = addr_q[23:22];
            addr_nxt  = addr_q[21:9];
            cnt_clr   = 1'b1;
            state_nxt = RD_TRCD;
         end
         RD_TRCD: begin
            if (cnt == TRCD_LAST) begin
               cnt_clr   = 1'b1;
               state_nxt = RD_READ;
            end
         end
         RD_READ: begin
            cmd_nxt   = CMD_READ;
            ba_nxt    = addr_q[23:22];
            addr_nxt  = {4'b0000, addr_q[8:0]};
            cnt_clr   = 1'b1;
            state_nxt = RD_DATA;
         end
         RD_DATA: begin
            if (cnt == 10'(len_q - 10'd1)) begin
               cmd_nxt   = CMD_BSTOP;
               cnt_clr   = 1'b1;
               state_nxt = RD_PRE;
            end
         end
         RD_PRE: begin
            cmd_nxt   = CMD_PRE;
            ba_nxt    = addr_q[23:22];
            addr_nxt  = 13'h0400;
            cnt_clr   = 1'b1;
            state_nxt = RD_TRP;
         end
         RD_TRP: begin
            if (cnt == TRP_LAST) begin
               cnt_clr   = 1'b1;
               state_nxt = RD_END;
            end
         end
         RD_END: begin
            cnt_clr   = 1'b1;
            state_nxt = RD_IDLE;
         end
         default: begin
            cnt_clr   = 1'b1;
            state_nxt = RD_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge sys_clk) begin
      if (sys_rst) state <= RD_IDLE;
      else         state <= state_nxt;
   end

   // Dwell counter, restarted on every state change
   always_ff @(posedge sys_clk) begin
      if (sys_rst || cnt_clr) cnt <= '0;
      else                    cnt <= cnt + 10'd1;
   end

   // Request latch; a zero length is treated as a single word
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         addr_q <= '0;
         len_q  <= '0;
      end else if (start) begin
         addr_q <= bus.rd_addr;
         len_q  <= (bus.rd_burst_len == 10'd0) ? 10'd1 : bus.rd_burst_len;
      end
   end

   // Registered command bus
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         bus.read_cmd  <= CMD_NOP;
         bus.read_ba   <= 2'b11;
         bus.read_addr <= 13'h1fff;
      end else begin
         bus.read_cmd  <= cmd_nxt;
         bus.read_ba   <= ba_nxt;
         bus.read_addr <= addr_nxt;
      end
   end

   // RD_DATA window delayed by CAS_LAT marks the cycles DQ carries a word; capture it one cycle later
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         dwin              <= '0;
         bus.rd_ack        <= 1'b0;
         bus.rd_sdram_data <= '0;
      end else begin
         dwin              <= {dwin[CAS_LAT-2:0], (state == RD_DATA)};
         bus.rd_ack        <= dwin[CAS_LAT-1];
         bus.rd_sdram_data <= dwin[CAS_LAT-1] ? bus.rd_data : 16'h0000;
      end
   end

   assign bus.rd_end = (state == RD_END);

endmodule
